puncturer: RTL and testbench

- Takes rate-1/2 coded pairs {A,B} from the convolutional encoder stage.
- Punctures them to rate 1/2, 2/3 or 3/4 according to `mode`.
- Emits the kept bits as a serial stream, one bit per cycle, with valid/ready flow control.
- Sits between the encoder and the interleaver. A small bit buffer absorbs the 2-bit-in / 1-bit-out rate mismatch.

---
 rtl/puncturer.sv | 129 ++++++++++++
 tb/tb_puncturer.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/puncturer.sv
// Puncturer: turns rate-1/2 coded pairs {A,B} into a serial bit stream
// punctured to rate 1/2, 2/3 or 3/4, buffered through a small bit FIFO.
// Optional build macro PUNCT_BIT_COUNT_EN adds a 16-bit popped-bit counter.
module puncturer #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned CNT_W = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [1:0] mode,
  input  logic [1:0] data_in,
  input  logic       data_in_valid,
  output logic       data_in_ready,
  output logic       data_out,
  output logic       data_out_valid,
  input  logic       data_out_ready
`ifdef PUNCT_BIT_COUNT_EN
  ,
  output logic [15:0] bit_count
`endif
);

  localparam logic [1:0] MODE_R34 = 2'd1;
  localparam logic [1:0] MODE_R23 = 2'd2;
  localparam int unsigned FULL_LIM = DEPTH - 2;

  logic [DEPTH-1:0] r_buf;
  logic [CNT_W-1:0] r_count;
  logic [1:0]       r_phase;
  logic [1:0]       r_mode_q;
  logic             r_data_out;
  logic             r_data_out_valid;

  logic             w_mode_chg;
  logic             w_push;
  logic             w_pop;
  logic             w_keep_a;
  logic             w_keep_b;
  logic             w_last_phase;
  logic [DEPTH-1:0] w_buf_nxt;
  logic [CNT_W-1:0] w_cnt_shift;
  logic [CNT_W-1:0] w_slot_b;
  logic [CNT_W-1:0] w_count_nxt;

  // Ready depends only on registered state plus reset/mode, never on data_out_ready
  assign w_mode_chg     = (mode != r_mode_q);
  assign data_in_ready  = !reset && (r_count <= CNT_W'(FULL_LIM)) && !w_mode_chg;
  assign w_push         = data_in_valid && data_in_ready;
  assign w_pop          = r_data_out_valid && data_out_ready;
  assign data_out       = r_data_out;
  assign data_out_valid = r_data_out_valid;

  // Keep pattern for the current phase; mode 3 falls through to rate 1/2
  always_comb begin
    w_keep_a     = 1'b1;
    w_keep_b     = 1'b1;
    w_last_phase = 1'b1;
    case (r_mode_q)
      MODE_R23: begin
        w_last_phase = (r_phase == 2'd1);
        if (r_phase == 2'd1) w_keep_b = 1'b0;
      end
      MODE_R34: begin
        w_last_phase = (r_phase == 2'd2);
        if (r_phase == 2'd1) w_keep_b = 1'b0;
        if (r_phase == 2'd2) w_keep_a = 1'b0;
      end
      default: ;
    endcase
  end

  // Buffer next state: shift out the head on pop, then append kept bits after the tail
  always_comb begin
    w_buf_nxt   = r_buf;
    w_cnt_shift = r_count;
    if (w_pop) begin
      w_buf_nxt   = {1'b0, r_buf[DEPTH-1:1]};
      w_cnt_shift = r_count - CNT_W'(1);
    end
    w_slot_b    = w_keep_a ? (w_cnt_shift + CNT_W'(1)) : w_cnt_shift;
    w_count_nxt = w_cnt_shift;
    if (w_push) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (w_keep_a && (CNT_W'(i) == w_cnt_shift)) w_buf_nxt[i] = data_in[1];
        if (w_keep_b && (CNT_W'(i) == w_slot_b))    w_buf_nxt[i] = data_in[0];
      end
      w_count_nxt = w_cnt_shift + CNT_W'(w_keep_a) + CNT_W'(w_keep_b);
    end
  end

  // State update; slots above the tail stay zero so an empty head reads 0
  always_ff @(posedge clock) begin
    if (reset) begin
      r_buf            <= '0;
      r_count          <= '0;
      r_phase          <= 2'd0;
      r_mode_q         <= 2'd0;
      r_data_out       <= 1'b0;
      r_data_out_valid <= 1'b0;
    end else begin
      r_buf            <= w_buf_nxt;
      r_count          <= w_count_nxt;
      r_data_out       <= w_buf_nxt[0];
      r_data_out_valid <= (w_count_nxt != '0);
      if (w_mode_chg) begin
        r_mode_q <= mode;
        r_phase  <= 2'd0;
      end else if (w_push) begin
        r_phase <= w_last_phase ? 2'd0 : (r_phase + 2'd1);
      end
    end
  end

`ifdef PUNCT_BIT_COUNT_EN
  logic [15:0] r_bit_count;

  // Count popped bits since reset, wrapping naturally at 16 bits
  always_ff @(posedge clock) begin
    if (reset) begin
      r_bit_count <= 16'd0;
    end else if (w_pop) begin
      r_bit_count <= r_bit_count + 16'd1;
    end
  end

  assign bit_count = r_bit_count;
`endif

endmodule

// File: tb/tb_puncturer.sv
// Self-checking bench for puncturer: queue-based reference model checked every
// cycle, plus literal expectations for the directed packets.
module tb_puncturer;

  localparam int unsigned DEPTH = 8;
  localparam int unsigned CNT_W = 4;

  logic       clock = 1'b0;
  logic       reset;
  logic [1:0] mode;
  logic [1:0] data_in;
  logic       data_in_valid;
  logic       data_in_ready;
  logic       data_out;
  logic       data_out_valid;
  logic       data_out_ready;
`ifdef PUNCT_BIT_COUNT_EN
  logic [15:0] bit_count;
`endif

  always #5 clock = ~clock;

  puncturer #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clock          (clock),
    .reset          (reset),
    .mode           (mode),
    .data_in        (data_in),
    .data_in_valid  (data_in_valid),
    .data_in_ready  (data_in_ready),
    .data_out       (data_out),
    .data_out_valid (data_out_valid),
    .data_out_ready (data_out_ready)
`ifdef PUNCT_BIT_COUNT_EN
    ,
    .bit_count      (bit_count)
`endif
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  // Reference model: a queue of kept bits plus the puncturing rule
  bit          m_q[$];
  int          m_phase = 0;
  logic [1:0]  m_mq = 2'd0;
  int unsigned m_bc = 0;
  bit          chk_en = 1'b0;
  bit          dut_log[$];

  function automatic int period(input logic [1:0] m);
    return (m == 2'd1) ? 3 : (m == 2'd2) ? 2 : 1;
  endfunction

  // Returns {keep_a, keep_b}
  function automatic logic [1:0] keep(input logic [1:0] m, input int ph);
    if (m == 2'd1) return (ph == 0) ? 2'b11 : (ph == 1) ? 2'b10 : 2'b01;
    if (m == 2'd2) return (ph == 0) ? 2'b11 : 2'b10;
    return 2'b11;
  endfunction

  always @(posedge clock) begin
    bit         er;
    bit         push;
    bit         pop;
    logic [1:0] k;
    if (reset) begin
      m_q.delete();
      m_phase = 0;
      m_mq    = 2'd0;
      m_bc    = 0;
    end else begin
      er   = (m_q.size() <= DEPTH - 2) && (mode == m_mq);
      push = data_in_valid && er;
      pop  = (m_q.size() != 0) && data_out_ready;
      if (pop) begin
        void'(m_q.pop_front());
        m_bc = (m_bc + 1) % 65536;
      end
      if (mode != m_mq) begin
        m_mq    = mode;
        m_phase = 0;
      end else if (push) begin
        k = keep(m_mq, m_phase);
        if (k[1]) m_q.push_back(data_in[1]);
        if (k[0]) m_q.push_back(data_in[0]);
        m_phase = (m_phase + 1) % period(m_mq);
      end
    end
    chk_en = 1'b1;
  end

  // Per-cycle comparison against the model; also logs every popped bit
  always @(negedge clock) begin
    bit ev;
    if (chk_en) begin
      ev = (m_q.size() != 0);
      check("out_valid", data_out_valid, ev);
      check("out_data", data_out, ev ? m_q[0] : 1'b0);
      check("in_ready", data_in_ready, !reset && (m_q.size() <= DEPTH - 2) && (mode == m_mq));
`ifdef PUNCT_BIT_COUNT_EN
      check("bit_count", bit_count, m_bc);
`endif
      if (!reset && data_out_valid && data_out_ready) dut_log.push_back(data_out);
    end
  end

  task automatic tick();
    @(posedge clock);
    #2;
  endtask

  task automatic send(input logic [1:0] p);
    int n = 0;
    bit acc;
    data_in       = p;
    data_in_valid = 1'b1;
    do begin
      @(negedge clock);
      acc = data_in_ready;
      tick();
      n++;
    end while (!acc && n < 100);
    check("send_accept", acc, 1'b1);
    data_in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    bit v;
    data_out_ready = 1'b1;
    do begin
      @(negedge clock);
      v = data_out_valid;
      tick();
      n++;
    end while (v && n < 300);
    check("drain_empty", v, 1'b0);
  endtask

  task automatic expect_log(input string name, input bit exp[$]);
    check({name, "_len"}, dut_log.size(), exp.size());
    for (int i = 0; i < exp.size() && i < dut_log.size(); i++)
      check(name, dut_log[i], exp[i]);
    dut_log.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    bit         exp[$];
    bit         bp[$];
    logic [1:0] p;
    logic [1:0] bp_pairs[4];
    int         n_acc;
    bit         acc;

    reset = 1'b1; mode = 2'd0; data_in = 2'd0; data_in_valid = 1'b0; data_out_ready = 1'b1;
    repeat (2) tick();
    @(negedge clock);
    check("rst_valid", data_out_valid, 1'b0);
    check("rst_data", data_out, 1'b0);
    check("rst_ready", data_in_ready, 1'b0);
    tick();
    reset = 1'b0;
    @(negedge clock);
    check("idle_ready", data_in_ready, 1'b1);
    tick();

    // Rate 1/2, 96 pairs, first pair 10 with one-cycle latency
    dut_log.delete(); exp.delete();
    send(2'b10);
    exp.push_back(1'b1); exp.push_back(1'b0);
    @(negedge clock);
    check("lat_valid", data_out_valid, 1'b1);
    check("lat_data", data_out, 1'b1);
    tick();
    for (int i = 1; i < 96; i++) begin
      p = 2'($urandom_range(0, 3));
      send(p);
      exp.push_back(p[1]); exp.push_back(p[0]);
    end
    drain();
    check("r12_count", exp.size(), 192);
    expect_log("r12_seq", exp);

    // Rate 2/3 directed packet
    mode = 2'd2;
    send(2'b11); send(2'b01); send(2'b10); send(2'b00);
    drain();
    exp = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    check("r23_model_phase", m_phase, 0);
    expect_log("r23_seq", exp);

    // Rate 3/4 directed packet, then 96 pairs
    mode = 2'd1;
    send(2'b10); send(2'b11); send(2'b01);
    drain();
    exp = '{1'b1, 1'b0, 1'b1, 1'b1};
    expect_log("r34_seq", exp);
    exp.delete();
    for (int i = 0; i < 96; i++) begin
      p = 2'($urandom_range(0, 3));
      send(p);
      if (i % 3 != 2) exp.push_back(p[1]);
      if (i % 3 != 1) exp.push_back(p[0]);
    end
    drain();
    check("r34_count", exp.size(), 128);
    expect_log("r34_long", exp);

    // Backpressure: rate 1/2 with consumer stalled
    mode = 2'd0;
    tick();
    data_out_ready = 1'b0;
    bp_pairs = '{2'b10, 2'b01, 2'b11, 2'b00};
    n_acc = 0;
    data_in = bp_pairs[0];
    data_in_valid = 1'b1;
    repeat (12) begin
      @(negedge clock);
      acc = data_in_ready;
      tick();
      if (acc) begin
        n_acc++;
        data_in = bp_pairs[n_acc % 4];
      end
    end
    data_in_valid = 1'b0;
    check("bp_accepted", n_acc, 4);
    @(negedge clock);
    check("bp_ready_low", data_in_ready, 1'b0);
    check("bp_head", data_out, 1'b1);
    check("bp_head_valid", data_out_valid, 1'b1);
    tick();
    data_out_ready = 1'b1;
    @(negedge clock);
    tick();
    @(negedge clock);
    check("bp_ready_at7", data_in_ready, 1'b0);
    tick();
    @(negedge clock);
    check("bp_ready_at6", data_in_ready, 1'b1);
    tick();
    drain();
    bp = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    expect_log("bp_seq", bp);

    // Mode switch 0 -> 1 with bits still buffered
    data_out_ready = 1'b0;
    send(2'b11);
    mode = 2'd1;
    @(negedge clock);
    check("sw_ready_low", data_in_ready, 1'b0);
    tick();
    @(negedge clock);
    check("sw_ready_back", data_in_ready, 1'b1);
    tick();
    send(2'b10);
    drain();
    exp = '{1'b1, 1'b1, 1'b1, 1'b0};
    expect_log("sw_seq", exp);

    // Reset with 5 bits buffered in rate 2/3
    mode = 2'd2;
    data_out_ready = 1'b0;
    send(2'b11); send(2'b01); send(2'b10);
    check("pre_rst_depth", m_q.size(), 5);
    @(negedge clock);
    check("pre_rst_valid", data_out_valid, 1'b1);
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    @(negedge clock);
    check("mid_rst_valid", data_out_valid, 1'b0);
    check("mid_rst_data", data_out, 1'b0);
    tick();
    dut_log.delete();
    send(2'b01);
    drain();
    exp = '{1'b0, 1'b1};
    expect_log("post_rst_seq", exp);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
